// File: rtl/clk_div_prog_if.sv
// ---------------------------------------------------------------------------
// clk_div_prog_if
// Bundles the per-channel control and status lines of the programmable
// clock divider so the block and its users share one port.
//   en      : per-channel run request (level)
//   load    : per-channel one-cycle strobe that captures div_in
//   div_in  : packed divisors, channel i in bits [i*DIV_W +: DIV_W]
//   clk_out : divided clocks, 50 % duty for both even and odd divisors
//   tick    : one-clk pulse at each clk_out rising edge
//   busy    : a loaded divisor is waiting for its period boundary
// The master modport is the controlling side; the slave modport is the
// divider itself.
// ---------------------------------------------------------------------------
interface clk_div_prog_if #(
  parameter int NCH   = 2,
  parameter int DIV_W = 8
);
  logic [NCH-1:0]       en;
  logic [NCH-1:0]       load;
  logic [NCH*DIV_W-1:0] div_in;
  logic [NCH-1:0]       clk_out;
  logic [NCH-1:0]       tick;
  logic [NCH-1:0]       busy;

  modport master (
    output en, load, div_in,
    input  clk_out, tick, busy
  );

  modport slave (
    input  en, load, div_in,
    output clk_out, tick, busy
  );
endinterface

// File: rtl/clk_div_prog.sv
// ---------------------------------------------------------------------------
// clk_div_prog
// Multi-channel runtime-programmable integer clock divider. Each channel
// divides clk by any D in 2..2^DIV_W-1 with 50 % duty. Even D uses only a
// posedge register; odd D ORs in a copy delayed by half a cycle on the
// negedge to stretch the high phase by exactly half a clk period.
// Divisor changes and enable/disable only take effect at period boundaries,
// so clk_out never produces a runt pulse.
// Ports:
//   clk : source clock (posedge counters, negedge half-cycle stretcher)
//   rst : asynchronous active-high reset
//   bus : clk_div_prog_if slave modport (en, load, div_in in;
//         clk_out, tick, busy out)
// ---------------------------------------------------------------------------
module clk_div_prog #(
  parameter int NCH     = 2,
  parameter int DIV_W   = 8,
  parameter int RST_DIV = 2
) (
  input  logic               clk,
  input  logic               rst,
  clk_div_prog_if.slave      bus
);

  localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);
  localparam logic [DIV_W-1:0] TWO     = DIV_W'(2);
  localparam logic [DIV_W-1:0] RST_VAL = DIV_W'(RST_DIV);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  logic [NCH-1:0] clk_out_w;
  logic [NCH-1:0] tick_w;
  logic [NCH-1:0] busy_w;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    state_t           state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_act_q, div_act_d;
    logic [DIV_W-1:0] div_pend_q, div_pend_d;
    logic             pend_v_q, pend_v_d;
    logic             p_q, p_d;
    logic             tick_q, tick_d;
    logic             n_q;

    logic [DIV_W-1:0] div_slice;
    logic [DIV_W-1:0] last_cnt;
    logic [DIV_W-1:0] cnt_inc;
    logic [DIV_W-1:0] d_eff;
    logic [DIV_W-1:0] h_eff;
    logic             at_boundary;
    logic             apply;
    logic             legal;

    assign div_slice = bus.div_in[i*DIV_W +: DIV_W];

    // The divisor that governs the next period: a pending one is taken
    // either immediately when the channel is stopped, or at the last
    // cycle of the running period. The pending value used is the one
    // already registered, so a load in the boundary cycle waits a period.
    always_comb begin
      last_cnt    = div_act_q - ONE;
      cnt_inc     = cnt_q + ONE;
      at_boundary = (state_q == ST_RUN) && (cnt_q == last_cnt);
      apply       = pend_v_q && ((state_q == ST_IDLE) || at_boundary);
      d_eff       = apply ? div_pend_q : div_act_q;
      h_eff       = d_eff >> 1;
      legal       = (d_eff >= TWO);
    end

    // Next-state logic. p is high for the first floor(D/2) counts of the
    // period; the period always ends with p low, which is what makes the
    // odd/even output select safe to change at a boundary.
    always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      div_act_d  = d_eff;
      div_pend_d = div_pend_q;
      pend_v_d   = pend_v_q & ~apply;
      p_d        = 1'b0;
      tick_d     = 1'b0;

      if (bus.load[i]) begin
        div_pend_d = div_slice;
        pend_v_d   = 1'b1;
      end

      case (state_q)
        ST_IDLE: begin
          cnt_d = '0;
          if (bus.en[i] && legal) begin
            state_d = ST_RUN;
            p_d     = 1'b1;
            tick_d  = 1'b1;
          end
        end
        ST_RUN: begin
          if (at_boundary) begin
            cnt_d = '0;
            if (!bus.en[i] || !legal) begin
              state_d = ST_IDLE;
            end else begin
              p_d    = 1'b1;
              tick_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_inc;
            p_d   = (cnt_inc < h_eff);
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    // Posedge state register.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q    <= ST_IDLE;
        cnt_q      <= '0;
        div_act_q  <= RST_VAL;
        div_pend_q <= '0;
        pend_v_q   <= 1'b0;
        p_q        <= 1'b0;
        tick_q     <= 1'b0;
      end else begin
        state_q    <= state_d;
        cnt_q      <= cnt_d;
        div_act_q  <= div_act_d;
        div_pend_q <= div_pend_d;
        pend_v_q   <= pend_v_d;
        p_q        <= p_d;
        tick_q     <= tick_d;
      end
    end

    // Half-cycle delayed copy of p used to stretch odd-divisor high phases.
    always_ff @(negedge clk or posedge rst) begin
      if (rst) begin
        n_q <= 1'b0;
      end else begin
        n_q <= p_q;
      end
    end

    assign clk_out_w[i] = div_act_q[0] ? (p_q | n_q) : p_q;
    assign tick_w[i]    = tick_q;
    assign busy_w[i]    = pend_v_q;
  end

  assign bus.clk_out = clk_out_w;
  assign bus.tick    = tick_w;
  assign bus.busy    = busy_w;

endmodule

// File: tb/tb_clk_div_prog.sv
// ---------------------------------------------------------------------------
// tb_clk_div_prog
// Self-checking bench for clk_div_prog with two channels. The reference
// model tracks, per channel, whether it runs, the active divisor and the
// position inside the current period; the expected clk_out is derived from
// the position in half-cycles (high for the first D of the 2*D half-cycles).
// ---------------------------------------------------------------------------
module tb_clk_div_prog;

  localparam int NCH     = 2;
  localparam int DW      = 8;
  localparam int RST_DIV = 2;

  logic clk;
  logic rst;

  clk_div_prog_if #(.NCH(NCH), .DIV_W(DW)) bus ();

  clk_div_prog #(.NCH(NCH), .DIV_W(DW), .RST_DIV(RST_DIV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks;
  int errors;

  int mRun   [NCH];
  int mK     [NCH];
  int mD     [NCH];
  int mPendD [NCH];
  int mPend  [NCH];

  // Free-running source clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case something keeps the stimulus from finishing.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model back to the reset state.
  function automatic void modelReset();
    for (int c = 0; c < NCH; c++) begin
      mRun[c]   = 0;
      mK[c]     = 0;
      mD[c]     = RST_DIV;
      mPendD[c] = 0;
      mPend[c]  = 0;
    end
  endfunction

  // Advance the model by one posedge using the inputs currently driven.
  function automatic void modelPosedge();
    int  dn;
    bit  apply;
    bit  last;
    for (int c = 0; c < NCH; c++) begin
      last  = (mRun[c] != 0) && (mK[c] == mD[c] - 1);
      apply = (mPend[c] != 0) && ((mRun[c] == 0) || last);
      dn    = apply ? mPendD[c] : mD[c];
      if (mRun[c] != 0) begin
        if (last) begin
          mK[c] = 0;
          if (!bus.en[c] || dn < 2) mRun[c] = 0;
        end else begin
          mK[c] = mK[c] + 1;
        end
      end else if (bus.en[c] && dn >= 2) begin
        mRun[c] = 1;
        mK[c]   = 0;
      end
      mD[c] = dn;
      if (apply) mPend[c] = 0;
      if (bus.load[c]) begin
        mPendD[c] = int'(bus.div_in[c*DW +: DW]);
        mPend[c]  = 1;
      end
    end
  endfunction

  // Compare every channel against the model for the current half-cycle.
  task automatic checkAll(input bit posHalf);
    int  hc;
    bit  expClk;
    for (int c = 0; c < NCH; c++) begin
      hc     = posHalf ? 2 * mK[c] : 2 * mK[c] + 1;
      expClk = (mRun[c] != 0) && (hc < mD[c]);
      checkOutput($sformatf("clk_out%0d_%s", c, posHalf ? "pos" : "neg"),
                  32'(bus.clk_out[c]), 32'(expClk));
      if (posHalf) begin
        checkOutput($sformatf("tick%0d", c), 32'(bus.tick[c]),
                    32'((mRun[c] != 0) && (mK[c] == 0)));
        checkOutput($sformatf("busy%0d", c), 32'(bus.busy[c]), 32'(mPend[c] != 0));
      end
    end
  endtask

  // Drive one cycle of inputs, then check after the posedge and negedge.
  task automatic applyStimulus(input logic [1:0] enS, input logic [1:0] loadS,
                               input int d0, input int d1);
    bus.en     = enS;
    bus.load   = loadS;
    bus.div_in = {DW'(d1), DW'(d0)};
    @(posedge clk);
    modelPosedge();
    #1 checkAll(1'b1);
    @(negedge clk);
    #1 checkAll(1'b0);
  endtask

  task automatic idleCycles(input logic [1:0] enS, input int n);
    for (int t = 0; t < n; t++) applyStimulus(enS, 2'b00, 0, 0);
  endtask

  // Run until channel 0 reaches the given count with the given divisor.
  task automatic waitCh0(input logic [1:0] enS, input int d, input int k);
    for (int t = 0; t < 60 && !(mRun[0] != 0 && mD[0] == d && mK[0] == k); t++)
      applyStimulus(enS, 2'b00, 0, 0);
  endtask

  initial begin
    logic [1:0] enR;
    logic [1:0] ldR;
    checks = 0;
    errors = 0;
    modelReset();
    bus.en     = '0;
    bus.load   = '0;
    bus.div_in = '0;
    rst        = 1'b1;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    checkOutput("rst_clk_out", 32'(bus.clk_out), 32'd0);
    checkOutput("rst_tick", 32'(bus.tick), 32'd0);
    checkOutput("rst_busy", 32'(bus.busy), 32'd0);
    rst = 1'b0;

    // Both channels at the reset divisor of 2.
    $display("[TB] reset divisor run");
    idleCycles(2'b11, 8);

    // Stop channel 0, load 4 while stopped, then run it; same for 5.
    $display("[TB] stopped loads D=4 and D=5");
    idleCycles(2'b10, 4);
    applyStimulus(2'b10, 2'b01, 4, 0);
    idleCycles(2'b11, 12);
    idleCycles(2'b10, 6);
    applyStimulus(2'b10, 2'b01, 5, 0);
    idleCycles(2'b11, 15);

    // Running D=4, load 7 at cnt=1.
    $display("[TB] running divisor change 4 -> 7");
    applyStimulus(2'b11, 2'b01, 4, 0);
    waitCh0(2'b11, 4, 1);
    applyStimulus(2'b11, 2'b01, 7, 0);
    idleCycles(2'b11, 22);

    // Drop en mid-period at D=6, then reassert.
    $display("[TB] stop and restart at D=6");
    applyStimulus(2'b11, 2'b01, 6, 0);
    waitCh0(2'b11, 6, 2);
    idleCycles(2'b10, 12);
    idleCycles(2'b11, 14);

    // Illegal divisor stops the channel; loading 3 restarts it.
    $display("[TB] illegal divisor stop");
    applyStimulus(2'b11, 2'b01, 3, 0);
    waitCh0(2'b11, 3, 1);
    applyStimulus(2'b11, 2'b01, 1, 0);
    idleCycles(2'b11, 10);
    applyStimulus(2'b11, 2'b01, 3, 0);
    idleCycles(2'b11, 10);

    // Two channels at 3 and 8, pending load, then reset mid-period.
    $display("[TB] reset mid-operation");
    applyStimulus(2'b11, 2'b11, 3, 8);
    idleCycles(2'b11, 13);
    applyStimulus(2'b11, 2'b11, 9, 9);
    rst = 1'b1;
    #1;
    checkOutput("midrst_clk_out", 32'(bus.clk_out), 32'd0);
    checkOutput("midrst_tick", 32'(bus.tick), 32'd0);
    checkOutput("midrst_busy", 32'(bus.busy), 32'd0);
    modelReset();
    #1 rst = 1'b0;
    idleCycles(2'b11, 10);

    // Randomized traffic against the model.
    $display("[TB] random phase");
    enR = 2'b11;
    for (int t = 0; t < 700; t++) begin
      for (int c = 0; c < NCH; c++) begin
        if ($urandom_range(0, 19) == 0) enR[c] = ~enR[c];
        ldR[c] = ($urandom_range(0, 7) == 0);
      end
      applyStimulus(enR, ldR, int'($urandom_range(0, 11)), int'($urandom_range(0, 11)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
